// File: rtl/ahb_lite_reg_bridge.sv
// AHB-Lite slave front end for the CSR bank.
// Converts single AHB-Lite transfers into word-indexed register-bus accesses.
// Writes complete with zero wait states. Reads take RD_WAIT_CYCLES wait states.
// Optional feature macro: AHB_ERR_RESP_EN. When it is defined, a bad access gets the
// two-cycle ERROR response. Without it, a bad access completes OKAY with reg_we
// suppressed and read data 0.
module ahb_lite_reg_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned RD_WAIT_CYCLES = 1  // legal range 1..3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_din,
  output logic        reg_we,
  input  logic [31:0] reg_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdWait,
    StRdDone,
    StErr1,
    StErr2
  } state_e;

  localparam logic [29:0] NumRegsW = 30'(NUM_REGS);
  localparam logic [1:0]  LastWait = 2'(RD_WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] reg_addr_q, reg_addr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        bad_q, bad_d;

  logic [32:0] diff;
  logic [31:0] offset;
  logic        borrow;
  logic        accept;
  logic        bad;
  logic        can_accept;

  // Only HTRANS[1] matters: BUSY and IDLE are both ignored.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Address-phase decode: window offset (with borrow), word index and legality.
  always_comb begin
    diff   = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    borrow = diff[32];
    offset = diff[31:0];
    accept = HSEL & HTRANS[1] & HREADY;
    bad    = borrow | (offset[31:2] >= NumRegsW) | (HADDR[1:0] != 2'b00) |
             (HSIZE != 3'b010);
  end

  // Next-state logic: WR, RD_DONE and ERR2 behave like IDLE so transfers can pipeline.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    reg_addr_d = reg_addr_q;
    hrdata_d   = hrdata_q;
    bad_d      = bad_q;
    can_accept = 1'b0;

    unique case (state_q)
      StIdle, StWr, StRdDone, StErr2: can_accept = 1'b1;
      StRdWait: begin
        if (wait_q == LastWait) begin
          // A bad read (only reachable without the ERROR response) returns zero.
          hrdata_d = bad_q ? 32'h0 : reg_dout;
          state_d  = StRdDone;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase

    if (can_accept) begin
      state_d = StIdle;
      if (accept) begin
        bad_d  = bad;
        wait_d = 2'd0;
        // Never present an out-of-range index to the CSR bank.
        if (!bad) begin
          reg_addr_d = {2'b00, offset[31:2]};
        end
`ifdef AHB_ERR_RESP_EN
        if (bad) begin
          state_d = StErr1;
        end else if (HWRITE) begin
          state_d = StWr;
        end else begin
          state_d = StRdWait;
        end
`else
        state_d = HWRITE ? StWr : StRdWait;
`endif
      end
    end
  end

  // State and captured-transfer registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= 2'd0;
      reg_addr_q <= 32'h0;
      hrdata_q   <= 32'h0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      reg_addr_q <= reg_addr_d;
      hrdata_q   <= hrdata_d;
      bad_q      <= bad_d;
    end
  end

  // Bus and register-side outputs decoded from the current state.
  always_comb begin
    HREADYOUT = !((state_q == StRdWait) || (state_q == StErr1));
    reg_we    = (state_q == StWr) && !bad_q;
`ifdef AHB_ERR_RESP_EN
    HRESP     = (state_q == StErr1) || (state_q == StErr2);
`else
    HRESP     = 1'b0;
`endif
  end

  assign reg_din  = HWDATA;
  assign reg_addr = reg_addr_q;
  assign HRDATA   = hrdata_q;

endmodule
